muldiv_seq: RTL and testbench
=============================

// Module: muldiv_seq
// PURPOSE
//  Iterative unsigned MULTU/DIVU sequencer that borrows the shared 32-bit ALU (add/sub/slt) for one op per cycle.
//  Sits beside EX: takes operands from the pipeline, requests the ALU through alu_req/alu_gnt, returns HI/LO.
//  The shared ALU exposes no carry, so the carry is recovered locally and division uses slt-then-sub.
// PARAMETERS
//  XLEN      32       operand width; only 32 is supported
//  ALU_ADD   4'b0010  ALU_Ctrl code for add
//  ALU_SUB   4'b0110  ALU_Ctrl code for sub
//  ALU_SLT   4'b0111  ALU_Ctrl code for unsigned less-than (result bit0)
// PORTS
//  clk        in   1   clock, rising edge
//  reset      in   1   asynchronous, active-low reset
//  start      in   1   launch op; sampled only in IDLE
//  op         in   1   0=MULTU, 1=DIVU
//  flush      in   1   synchronous abort of the op in flight
//  rs_val     in   32  multiplicand / dividend
//  rt_val     in   32  multiplier / divisor
//  alu_gnt    in   1   ALU granted this cycle
//  alu_result in   32  shared ALU result
//  alu_req    out  1   ALU requested this cycle
//  alu_a      out  32  ALU operand a
//  alu_b      out  32  ALU operand b
//  alu_ctrl   out  4   ALU_Ctrl
//  busy       out  1   op in flight (state != IDLE)
//  done       out  1   one-cycle pulse; hi/lo valid
//  hi         out  32  product[63:32] / remainder
//  lo         out  32  product[31:0] / quotient
//  div_zero   out  1   last DIVU had rt_val==0; held until next start
// BEHAVIOUR
//  Reset (async, low): state=IDLE, cnt=0. Outputs: busy, done, alu_req, div_zero = 0; hi, lo, alu_a, alu_b = 0; alu_ctrl=ALU_ADD.
//  FSM states: IDLE, MUL, DCMP, DSUB, DONE. A 6-bit iteration counter counts 0..31.
//  IDLE + start, op=0: lo<=rt_val, hi<=0, mcand<=rs_val -> MUL.
//  IDLE + start, op=1, rt_val!=0: lo<=rs_val, hi<=0, dvsr<=rt_val -> DCMP.
//  IDLE + start, op=1, rt_val==0: hi<=rs_val, lo<=32'hFFFFFFFF, div_zero<=1 -> DONE. No ALU use.
//  alu_req=1 in MUL/DCMP/DSUB. If alu_gnt=0, every register holds; the iteration repeats next cycle.
//  MUL, per granted cycle: alu_a=hi, alu_b=lo[0]?mcand:0, ctrl=ADD; c=(alu_result<hi).
//   Update {hi,lo}<={c,alu_result,lo[31:1]}. After iteration 31 -> DONE.
//  DCMP: sh={hi[30:0],lo[31]}; alu_a=sh, alu_b=dvsr, ctrl=SLT; ge<=hi[31]|~alu_result[0].
//   Update hi<=sh, lo<={lo[30:0],1'b0} -> DSUB.
//  DSUB: alu_a=hi, alu_b=dvsr, ctrl=SUB. If ge: hi<=alu_result, lo[0]<=1. 32-bit wrap is correct when hi[31] was set.
//   After iteration 31 -> DONE, else -> DCMP.
//  DONE: done=1 for exactly one cycle -> IDLE. hi/lo hold until the next start.
//  Latency with gnt always 1, start sampled at edge 0: MULTU done in cycle 33, DIVU in cycle 65, divide-by-zero in cycle 1.
//  start while busy: ignored. flush (any non-IDLE state): -> IDLE next edge, no done, hi/lo keep partial values.
//  flush and start together in IDLE: flush wins, nothing launches.
//  Reset mid-op: immediate IDLE with all outputs at reset values.
//  Outside MUL/DCMP/DSUB: alu_a=alu_b=0, alu_ctrl=ALU_ADD.
// STRUCTURE
//  muldiv_pkg holds the shared constants: ALU_ADD/ALU_SUB/ALU_SLT, op encodings MD_MULTU/MD_DIVU, FSM state encoding.
//  Single module, no sub-module: FSM, counter and operand muxes are small enough to live together.
// TESTING
//  MULTU 7*6, gnt=1 -> done in cycle 33, hi=0, lo=42, alu_req high for cycles 1..32.
//  MULTU FFFFFFFF*FFFFFFFF -> hi=FFFFFFFE, lo=00000001 (exercises the local carry).
//  DIVU 100/7 -> done in cycle 65, lo=14, hi=2. DIVU FFFFFFFF/1 -> lo=FFFFFFFF, hi=0 (hi[31] path).
//  DIVU 5/0 -> done in cycle 1, hi=5, lo=FFFFFFFF, div_zero=1, alu_req never high.
//  MULTU 7*6 with alu_gnt low every other cycle -> same result, done in cycle 65; start pulses while busy are ignored.
//  flush at cycle 10 of DIVU -> no done, busy=0 next cycle. Reset low mid-MULTU -> hi=lo=0, busy=0 immediately.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared constants for the iterative MULTU/DIVU sequencer: ALU control
// codes understood by the shared EX-stage ALU, op encodings and the FSM
// state encoding.
package muldiv_pkg;

    localparam int XLEN = 32;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    localparam logic MD_MULTU = 1'b0;
    localparam logic MD_DIVU  = 1'b1;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_MUL  = 3'd1;
    localparam logic [2:0] ST_DCMP = 3'd2;
    localparam logic [2:0] ST_DSUB = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    localparam logic [5:0] LAST_ITER = 6'd31;

endpackage

// File: rtl/muldiv_seq.sv
// Iterative unsigned MULTU/DIVU sequencer. It borrows the shared 32-bit ALU
// one operation per granted cycle: shift-add for multiply (carry recovered
// locally since the ALU has none) and restoring division as slt-then-sub.
module muldiv_seq
    import muldiv_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            op,
    input  logic            flush,
    input  logic [XLEN-1:0] rs_val,
    input  logic [XLEN-1:0] rt_val,
    input  logic            alu_gnt,
    input  logic [XLEN-1:0] alu_result,
    output logic            alu_req,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_ctrl,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo,
    output logic            div_zero
);

    logic [2:0]      state;
    logic [5:0]      cnt;
    logic [XLEN-1:0] hi_q;
    logic [XLEN-1:0] lo_q;
    logic [XLEN-1:0] mcand;
    logic [XLEN-1:0] dvsr;
    logic            ge;
    logic            div_zero_q;
    logic [XLEN-1:0] shifted;
    logic            carry;

    // The partial remainder shifted left by one, pulling in the next dividend bit.
    assign shifted = {hi_q[XLEN-2:0], lo_q[XLEN-1]};

    // An unsigned add wrapped around exactly when the sum is below an addend.
    assign carry = (alu_result < hi_q);

    assign busy     = (state != ST_IDLE);
    assign done     = (state == ST_DONE);
    assign hi       = hi_q;
    assign lo       = lo_q;
    assign div_zero = div_zero_q;

    // Drive the shared ALU's operands and control for the current iteration step.
    always_comb begin
        alu_req  = 1'b0;
        alu_a    = '0;
        alu_b    = '0;
        alu_ctrl = ALU_ADD;
        case (state)
            ST_MUL: begin
                alu_req  = 1'b1;
                alu_a    = hi_q;
                alu_b    = lo_q[0] ? mcand : '0;
                alu_ctrl = ALU_ADD;
            end
            ST_DCMP: begin
                alu_req  = 1'b1;
                alu_a    = shifted;
                alu_b    = dvsr;
                alu_ctrl = ALU_SLT;
            end
            ST_DSUB: begin
                alu_req  = 1'b1;
                alu_a    = hi_q;
                alu_b    = dvsr;
                alu_ctrl = ALU_SUB;
            end
            default: begin
                alu_req  = 1'b0;
            end
        endcase
    end

    // FSM, iteration counter and the HI/LO datapath; every register holds while the ALU is not granted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            mcand      <= '0;
            dvsr       <= '0;
            ge         <= 1'b0;
            div_zero_q <= 1'b0;
        end else if (flush) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        cnt        <= '0;
                        div_zero_q <= 1'b0;
                        if (op == MD_MULTU) begin
                            lo_q  <= rt_val;
                            hi_q  <= '0;
                            mcand <= rs_val;
                            state <= ST_MUL;
                        end else if (rt_val != '0) begin
                            lo_q  <= rs_val;
                            hi_q  <= '0;
                            dvsr  <= rt_val;
                            state <= ST_DCMP;
                        end else begin
                            hi_q       <= rs_val;
                            lo_q       <= '1;
                            div_zero_q <= 1'b1;
                            state      <= ST_DONE;
                        end
                    end
                end
                ST_MUL: begin
                    if (alu_gnt) begin
                        hi_q <= {carry, alu_result[XLEN-1:1]};
                        lo_q <= {alu_result[0], lo_q[XLEN-1:1]};
                        if (cnt == LAST_ITER) begin
                            cnt   <= '0;
                            state <= ST_DONE;
                        end else begin
                            cnt <= cnt + 6'd1;
                        end
                    end
                end
                ST_DCMP: begin
                    if (alu_gnt) begin
                        ge    <= hi_q[XLEN-1] | ~alu_result[0];
                        hi_q  <= shifted;
                        lo_q  <= {lo_q[XLEN-2:0], 1'b0};
                        state <= ST_DSUB;
                    end
                end
                ST_DSUB: begin
                    if (alu_gnt) begin
                        if (ge) begin
                            hi_q    <= alu_result;
                            lo_q[0] <= 1'b1;
                        end
                        if (cnt == LAST_ITER) begin
                            cnt   <= '0;
                            state <= ST_DONE;
                        end else begin
                            cnt   <= cnt + 6'd1;
                            state <= ST_DCMP;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed corner cases plus randomized
// MULTU/DIVU ops under random ALU grant patterns, compared against plain
// 64-bit arithmetic and a grant-count latency model.
module tb_muldiv_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic        op;
    logic        flush;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        alu_gnt;
    logic [31:0] alu_result;
    logic        alu_req;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_ctrl;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_zero;

    int total;
    int bad;
    bit gnt_pat [300];

    muldiv_seq dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .op         (op),
        .flush      (flush),
        .rs_val     (rs_val),
        .rt_val     (rt_val),
        .alu_gnt    (alu_gnt),
        .alu_result (alu_result),
        .alu_req    (alu_req),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_ctrl   (alu_ctrl),
        .busy       (busy),
        .done       (done),
        .hi         (hi),
        .lo         (lo),
        .div_zero   (div_zero)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behaviour of the shared EX-stage ALU as seen by the sequencer.
    always_comb begin
        alu_result = '0;
        case (alu_ctrl)
            4'b0010: alu_result = alu_a + alu_b;
            4'b0110: alu_result = alu_a - alu_b;
            4'b0111: alu_result = {31'b0, (alu_a < alu_b)};
            default: alu_result = '0;
        endcase
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Launch one op and follow it to completion, checking request, latency and result.
    // gnt_mode: 0 = grant always, 1 = grant on even cycles only, 2 = random grant.
    task automatic applyStimulus(input logic op_i, input logic [31:0] a, input logic [31:0] b,
                                 input int gnt_mode, input bit poke_start);
        int          need;
        int          seen;
        int          exp_done;
        int          cyc;
        bit          dz;
        bit          finished;
        logic [63:0] exp_res;

        for (int k = 0; k < 300; k++) begin
            if (gnt_mode == 0)      gnt_pat[k] = 1'b1;
            else if (gnt_mode == 1) gnt_pat[k] = (k % 2 == 0);
            else                    gnt_pat[k] = ($urandom_range(3, 0) != 0);
        end

        dz = (op_i == 1'b1) && (b == 32'd0);
        if (dz)
            exp_res = {a, 32'hFFFFFFFF};
        else if (op_i == 1'b0)
            exp_res = 64'(a) * 64'(b);
        else
            exp_res = {a % b, a / b};

        need     = (op_i == 1'b1) ? 64 : 32;
        exp_done = 0;
        if (dz) begin
            exp_done = 1;
        end else begin
            seen = 0;
            for (int k = 1; k < 300; k++) begin
                if (exp_done == 0 && gnt_pat[k]) begin
                    seen++;
                    if (seen == need) exp_done = k + 1;
                end
            end
        end

        @(negedge clk);
        start   = 1'b1;
        op      = op_i;
        rs_val  = a;
        rt_val  = b;
        alu_gnt = 1'b0;
        @(posedge clk);
        #1;
        start    = 1'b0;
        cyc      = 1;
        finished = 1'b0;
        while (!finished && cyc < 300) begin
            alu_gnt = gnt_pat[cyc];
            if (poke_start && (cyc % 7 == 3) && cyc < exp_done) begin
                start  = 1'b1;
                op     = ~op_i;
                rs_val = $urandom;
                rt_val = $urandom;
            end else begin
                start = 1'b0;
            end
            checkOutput("alu_req", 64'(alu_req), 64'(cyc < exp_done && !dz));
            checkOutput("done", 64'(done), 64'(cyc == exp_done));
            if (done) begin
                finished = 1'b1;
                checkOutput("hi", 64'(hi), 64'(exp_res[63:32]));
                checkOutput("lo", 64'(lo), 64'(exp_res[31:0]));
                checkOutput("div_zero", 64'(div_zero), 64'(dz));
                checkOutput("busy_at_done", 64'(busy), 64'd1);
                checkOutput("alu_ctrl_idle", 64'(alu_ctrl), 64'(4'b0010));
                checkOutput("alu_a_idle", 64'(alu_a), 64'd0);
            end else begin
                @(posedge clk);
                #1;
                cyc++;
            end
        end
        start   = 1'b0;
        alu_gnt = 1'b0;
        if (!finished) checkOutput("timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        checkOutput("busy_after", 64'(busy), 64'd0);
        checkOutput("done_after", 64'(done), 64'd0);
        checkOutput("hi_hold", 64'(hi), 64'(exp_res[63:32]));
        checkOutput("lo_hold", 64'(lo), 64'(exp_res[31:0]));
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rop;

        total   = 0;
        bad     = 0;
        reset   = 1'b0;
        start   = 1'b0;
        op      = 1'b0;
        flush   = 1'b0;
        rs_val  = '0;
        rt_val  = '0;
        alu_gnt = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        checkOutput("rst_req", 64'(alu_req), 64'd0);
        checkOutput("rst_dz", 64'(div_zero), 64'd0);
        checkOutput("rst_hi", 64'(hi), 64'd0);
        checkOutput("rst_lo", 64'(lo), 64'd0);
        checkOutput("rst_alu_a", 64'(alu_a), 64'd0);
        checkOutput("rst_alu_b", 64'(alu_b), 64'd0);
        checkOutput("rst_ctrl", 64'(alu_ctrl), 64'(4'b0010));
        reset = 1'b1;

        $display("[TB] directed ops");
        applyStimulus(1'b0, 32'd7, 32'd6, 0, 1'b0);
        applyStimulus(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1'b0);
        applyStimulus(1'b1, 32'd100, 32'd7, 0, 1'b0);
        applyStimulus(1'b1, 32'hFFFFFFFF, 32'd1, 0, 1'b0);
        applyStimulus(1'b1, 32'd5, 32'd0, 0, 1'b0);
        applyStimulus(1'b0, 32'd7, 32'd6, 1, 1'b1);
        applyStimulus(1'b1, 32'h80000000, 32'hFFFFFFFF, 2, 1'b1);

        $display("[TB] random ops");
        for (int i = 0; i < 24; i++) begin
            rop = 1'($urandom_range(1, 0));
            ra  = $urandom;
            case ($urandom_range(3, 0))
                0:       rb = $urandom_range(15, 0);
                1:       rb = $urandom >> $urandom_range(31, 0);
                default: rb = $urandom;
            endcase
            applyStimulus(rop, ra, rb, 2, (i % 3 == 0));
        end

        $display("[TB] flush during DIVU");
        @(negedge clk);
        start = 1'b1; op = 1'b1; rs_val = 32'd100; rt_val = 32'd7; alu_gnt = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        checkOutput("flush_busy_before", 64'(busy), 64'd1);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        checkOutput("flush_busy", 64'(busy), 64'd0);
        checkOutput("flush_done", 64'(done), 64'd0);
        checkOutput("flush_req", 64'(alu_req), 64'd0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            checkOutput("flush_no_done", 64'(done), 64'd0);
        end

        $display("[TB] flush with start in idle");
        @(negedge clk);
        flush = 1'b1; start = 1'b1; op = 1'b0; rs_val = 32'd3; rt_val = 32'd4;
        @(posedge clk);
        #1;
        flush = 1'b0; start = 1'b0;
        checkOutput("fs_busy", 64'(busy), 64'd0);
        checkOutput("fs_req", 64'(alu_req), 64'd0);

        $display("[TB] reset during MULTU");
        applyStimulus(1'b1, 32'd9, 32'd0, 0, 1'b0);
        @(negedge clk);
        start = 1'b1; op = 1'b0; rs_val = 32'd7; rt_val = 32'd6; alu_gnt = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        checkOutput("mid_rst_hi", 64'(hi), 64'd0);
        checkOutput("mid_rst_lo", 64'(lo), 64'd0);
        checkOutput("mid_rst_busy", 64'(busy), 64'd0);
        checkOutput("mid_rst_req", 64'(alu_req), 64'd0);
        checkOutput("mid_rst_dz", 64'(div_zero), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        applyStimulus(1'b0, 32'd12345, 32'd678, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard time limit so a hung design still ends the run.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog");
    end

endmodule
